// File: rtl/cache_mem_arbiter_if.sv
// Bus bundle between the two cache controllers, the arbiter and the shared memory port.
// The arbiter takes the slave view; whatever drives requests and models memory takes the master view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
);
  logic                 inst_rd_en;
  logic [ADDR_SIZE-1:0] inst_addr;
  logic                 inst_ack;
  logic [DATA_SIZE-1:0] inst_rd_data;

  logic                 data_rd_en;
  logic                 data_wr_en;
  logic [ADDR_SIZE-1:0] data_addr;
  logic [DATA_SIZE-1:0] data_wr_data;
  logic                 data_ack;
  logic [DATA_SIZE-1:0] data_rd_data;

  logic                 mem_rd_en;
  logic                 mem_wr_en;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wr_data;
  logic [DATA_SIZE-1:0] mem_rd_data;
  logic                 mem_ack;

  modport slave (
    input  inst_rd_en, inst_addr,
    input  data_rd_en, data_wr_en, data_addr, data_wr_data,
    input  mem_rd_data, mem_ack,
    output inst_ack, inst_rd_data,
    output data_ack, data_rd_data,
    output mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );

  modport master (
    output inst_rd_en, inst_addr,
    output data_rd_en, data_wr_en, data_addr, data_wr_data,
    output mem_rd_data, mem_ack,
    input  inst_ack, inst_rd_data,
    input  data_ack, data_rd_data,
    input  mem_rd_en, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the I-cache and D-cache controllers.
// The winning request is latched in Idle and held stable on the memory bus until mem_ack.
module cache_mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 128
) (
  input  logic                clock,
  input  logic                reset,
  cache_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_INST = 2'd1,
    SERVE_DATA = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;  // 0 = inst, 1 = data
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] wr_data_q, wr_data_d;
  logic                 op_wr_q, op_wr_d;

  logic inst_req;
  logic data_req;
  logic grant_data;

  assign inst_req   = bus.inst_rd_en;
  assign data_req   = bus.data_rd_en | bus.data_wr_en;
  // On a tie the requester that did not win last time gets the port.
  assign grant_data = data_req & (~inst_req | ~last_grant_q);

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wr_data_q    <= '0;
      op_wr_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      op_wr_q      <= op_wr_d;
    end
  end

  // NOTE: every signal gets a hold-value default up front so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    op_wr_d      = op_wr_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d   = SERVE_DATA;
          addr_d    = bus.data_addr;
          wr_data_d = bus.data_wr_data;
          op_wr_d   = bus.data_wr_en;  // write wins over a simultaneous read
        end else if (inst_req) begin
          state_d   = SERVE_INST;
          addr_d    = bus.inst_addr;
          wr_data_d = '0;
          op_wr_d   = 1'b0;
        end
      end
      SERVE_INST: begin
        if (bus.mem_ack) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      SERVE_DATA: begin
        if (bus.mem_ack) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_rd_en    = 1'b0;
    bus.mem_wr_en    = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wr_data  = '0;
    bus.inst_ack     = 1'b0;
    bus.inst_rd_data = '0;
    bus.data_ack     = 1'b0;
    bus.data_rd_data = '0;
    if (state_q != IDLE) begin
      bus.mem_rd_en   = ~op_wr_q;
      bus.mem_wr_en   = op_wr_q;
      bus.mem_addr    = addr_q;
      bus.mem_wr_data = wr_data_q;
    end
    case (state_q)
      SERVE_INST: begin
        bus.inst_ack = bus.mem_ack;
        if (bus.mem_ack) bus.inst_rd_data = bus.mem_rd_data;
      end
      SERVE_DATA: begin
        bus.data_ack = bus.mem_ack;
        if (bus.mem_ack) bus.data_rd_data = bus.mem_rd_data;
      end
      default: ;
    endcase
  end

endmodule
